fp_mac_param: RTL and testbench

Parametrised floating-point multiply-accumulate unit; next generation of the fixed-format tt_um_fp_mac core.
- Computes acc <= acc + a*b, or acc <= a*b when op_clear is set, in a configurable EXP_W/MAN_W format (default FP8 E4M3).
- Multi-cycle FSM with a valid/ready input handshake, a result-valid pulse, and sticky overflow/underflow flags.
- Sits behind the tt_um_* pin-wrapper, which serialises ui_in/uio_in bytes into the operand ports.

---
 rtl/fp_mac_param.sv | 289 ++++++++++++++++++++++++++++
 tb/tb_fp_mac_param.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fp_mac_param.sv
// Parametrised floating-point multiply-accumulate: acc <= acc + a*b (or a*b on op_clear).
// Five-state pipeline-in-time FSM, round toward zero, saturating, denormals flushed.
//
//   state   | meaning
//   --------+------------------------------------------------------------
//   S_IDLE  | in_ready high; operands and op_clear captured on accept
//   S_MUL   | sign/exponent/significand product of captured operands
//   S_ALIGN | product and accumulator brought to a common exponent
//   S_ADD   | signed-magnitude add/subtract of aligned significands
//   S_NORM  | normalise, saturate/flush, write acc_out, pulse out_valid
module fp_mac_param #(
   parameter int EXP_W = 4,
   parameter int MAN_W = 3,
   parameter int GRD_W = 3
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [EXP_W+MAN_W:0]   a_in,
   input  logic [EXP_W+MAN_W:0]   b_in,
   input  logic                   op_clear,
   output logic                   out_valid,
   output logic [EXP_W+MAN_W:0]   acc_out,
   output logic                   ovf,
   output logic                   unf
);

   localparam int W     = 1 + EXP_W + MAN_W;
   localparam int SIG_W = MAN_W + 1 + GRD_W;
   localparam int PW    = 2 * (MAN_W + 1);
   localparam int XW    = PW + GRD_W;
   localparam int EPW   = EXP_W + 2;
   localparam int EW    = EXP_W + 3;
   localparam int BIAS  = 2 ** (EXP_W - 1) - 1;
   localparam int EMAX  = 2 ** EXP_W - 1;

   localparam logic signed [EW-1:0] EMAX_S = EW'(EMAX);
   localparam logic signed [EW-1:0] E_ONE  = EW'(1);
   localparam logic        [EW-1:0] SH_MAX = EW'(SIG_W);

   typedef enum logic [2:0] {S_IDLE, S_MUL, S_ALIGN, S_ADD, S_NORM} state_t;

   state_t                  state_q, state_d;
   logic [W-1:0]            a_q, a_d, b_q, b_d;
   logic                    clr_q, clr_d;
   logic                    p_zero_q, p_zero_d, p_sign_q, p_sign_d;
   logic signed [EPW-1:0]   p_exp_q, p_exp_d;
   logic [SIG_W-1:0]        p_sig_q, p_sig_d;
   logic [SIG_W-1:0]        x_mag_q, x_mag_d, y_mag_q, y_mag_d;
   logic                    x_sign_q, x_sign_d, y_sign_q, y_sign_d;
   logic signed [EW-1:0]    al_exp_q, al_exp_d;
   logic                    r_sign_q, r_sign_d;
   logic [SIG_W:0]          r_mag_q, r_mag_d;
   logic signed [EW-1:0]    r_exp_q, r_exp_d;
   logic [W-1:0]            acc_q, acc_d;
   logic                    ovf_q, ovf_d, unf_q, unf_d;
   logic                    out_valid_q, out_valid_d;

   // MUL datapath
   logic [PW-1:0]           mul_prod;
   logic [PW-2:0]           mul_norm;
   logic signed [EPW-1:0]   mul_exp;
   logic [SIG_W-1:0]        mul_sig;
   logic                    mul_zero;

   always_comb begin
      mul_prod = PW'({1'b1, a_q[MAN_W-1:0]}) * PW'({1'b1, b_q[MAN_W-1:0]});
      mul_exp  = EPW'(a_q[W-2:MAN_W]) + EPW'(b_q[W-2:MAN_W]) - EPW'(BIAS);
      if (mul_prod[PW-1]) begin
         mul_norm = mul_prod[PW-1:1];
         mul_exp  = mul_exp + EPW'(1);
      end else begin
         mul_norm = mul_prod[PW-2:0];
      end
      // Keep MAN_W+GRD_W fraction bits of the 2*MAN_W-fraction product.
      mul_sig  = SIG_W'(XW'(mul_norm) << GRD_W >> MAN_W);
      mul_zero = (a_q[W-2:MAN_W] == '0) || (b_q[W-2:MAN_W] == '0);
   end

   // ALIGN datapath: x is the product side, y the accumulator side
   logic                    acc_zero;
   logic [SIG_W-1:0]        acc_sig, al_x, al_y;
   logic signed [EW-1:0]    pe, ae, diff, al_e;
   logic [EW-1:0]           sh;

   always_comb begin
      acc_zero = clr_q || (acc_q[W-2:MAN_W] == '0);
      acc_sig  = {1'b1, acc_q[MAN_W-1:0], {GRD_W{1'b0}}};
      pe       = {p_exp_q[EPW-1], p_exp_q};
      ae       = EW'(acc_q[W-2:MAN_W]);
      diff     = pe - ae;
      sh       = diff[EW-1] ? -diff : diff;
      al_x     = p_sig_q;
      al_y     = acc_sig;
      al_e     = pe;
      if (p_zero_q && acc_zero) begin
         al_x = '0;
         al_y = '0;
         al_e = '0;
      end else if (p_zero_q) begin
         al_x = '0;
         al_e = ae;
      end else if (acc_zero) begin
         al_y = '0;
      end else if (!diff[EW-1]) begin
         al_y = (sh > SH_MAX) ? '0 : (acc_sig >> sh);
      end else begin
         al_x = (sh > SH_MAX) ? '0 : (p_sig_q >> sh);
         al_e = ae;
      end
   end

   // ADD datapath
   logic                    add_sign;
   logic [SIG_W:0]          add_mag;

   always_comb begin
      add_sign = x_sign_q;
      add_mag  = {1'b0, x_mag_q} + {1'b0, y_mag_q};
      if (x_sign_q != y_sign_q) begin
         if (x_mag_q >= y_mag_q) begin
            add_mag = {1'b0, x_mag_q} - {1'b0, y_mag_q};
         end else begin
            add_mag  = {1'b0, y_mag_q} - {1'b0, x_mag_q};
            add_sign = y_sign_q;
         end
      end
      if (add_mag == '0) add_sign = 1'b0;
   end

   // NORM datapath
   logic [EW-1:0]           lz;
   logic                    found;
   logic [SIG_W:0]          nrm_m;
   logic signed [EW-1:0]    nrm_e;
   logic [W-1:0]            nrm_res;
   logic                    nrm_ovf, nrm_unf;

   always_comb begin
      lz      = '0;
      found   = 1'b0;
      nrm_res = '0;
      nrm_ovf = 1'b0;
      nrm_unf = 1'b0;
      for (int i = SIG_W - 1; i >= 0; i--) begin
         if (!found) begin
            if (r_mag_q[i]) found = 1'b1;
            else            lz    = lz + EW'(1);
         end
      end
      if (r_mag_q[SIG_W]) begin
         nrm_m = r_mag_q >> 1;
         nrm_e = r_exp_q + E_ONE;
      end else begin
         nrm_m = r_mag_q << lz;
         nrm_e = r_exp_q - $signed(lz);
      end
      if (r_mag_q != '0) begin
         if (nrm_e > EMAX_S) begin
            nrm_res = {r_sign_q, {(W-1){1'b1}}};
            nrm_ovf = 1'b1;
         end else if (nrm_e < E_ONE) begin
            nrm_unf = 1'b1;
         end else begin
            nrm_res = {r_sign_q, EXP_W'(nrm_e), MAN_W'(nrm_m >> GRD_W)};
         end
      end
   end

   always_comb begin
      state_d     = state_q;
      a_d         = a_q;
      b_d         = b_q;
      clr_d       = clr_q;
      p_zero_d    = p_zero_q;
      p_sign_d    = p_sign_q;
      p_exp_d     = p_exp_q;
      p_sig_d     = p_sig_q;
      x_mag_d     = x_mag_q;
      y_mag_d     = y_mag_q;
      x_sign_d    = x_sign_q;
      y_sign_d    = y_sign_q;
      al_exp_d    = al_exp_q;
      r_sign_d    = r_sign_q;
      r_mag_d     = r_mag_q;
      r_exp_d     = r_exp_q;
      acc_d       = acc_q;
      ovf_d       = ovf_q;
      unf_d       = unf_q;
      out_valid_d = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (in_valid) begin
               a_d     = a_in;
               b_d     = b_in;
               clr_d   = op_clear;
               state_d = S_MUL;
               if (op_clear) begin
                  ovf_d = 1'b0;
                  unf_d = 1'b0;
               end
            end
         end
         S_MUL: begin
            p_zero_d = mul_zero;
            p_sign_d = a_q[W-1] ^ b_q[W-1];
            p_exp_d  = mul_exp;
            p_sig_d  = mul_sig;
            state_d  = S_ALIGN;
         end
         S_ALIGN: begin
            x_mag_d  = al_x;
            y_mag_d  = al_y;
            x_sign_d = p_sign_q;
            y_sign_d = acc_q[W-1];
            al_exp_d = al_e;
            state_d  = S_ADD;
         end
         S_ADD: begin
            r_sign_d = add_sign;
            r_mag_d  = add_mag;
            r_exp_d  = al_exp_q;
            state_d  = S_NORM;
         end
         S_NORM: begin
            acc_d       = nrm_res;
            ovf_d       = ovf_q | nrm_ovf;
            unf_d       = unf_q | nrm_unf;
            out_valid_d = 1'b1;
            state_d     = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= S_IDLE;
         a_q         <= '0;
         b_q         <= '0;
         clr_q       <= 1'b0;
         p_zero_q    <= 1'b0;
         p_sign_q    <= 1'b0;
         p_exp_q     <= '0;
         p_sig_q     <= '0;
         x_mag_q     <= '0;
         y_mag_q     <= '0;
         x_sign_q    <= 1'b0;
         y_sign_q    <= 1'b0;
         al_exp_q    <= '0;
         r_sign_q    <= 1'b0;
         r_mag_q     <= '0;
         r_exp_q     <= '0;
         acc_q       <= '0;
         ovf_q       <= 1'b0;
         unf_q       <= 1'b0;
         out_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         a_q         <= a_d;
         b_q         <= b_d;
         clr_q       <= clr_d;
         p_zero_q    <= p_zero_d;
         p_sign_q    <= p_sign_d;
         p_exp_q     <= p_exp_d;
         p_sig_q     <= p_sig_d;
         x_mag_q     <= x_mag_d;
         y_mag_q     <= y_mag_d;
         x_sign_q    <= x_sign_d;
         y_sign_q    <= y_sign_d;
         al_exp_q    <= al_exp_d;
         r_sign_q    <= r_sign_d;
         r_mag_q     <= r_mag_d;
         r_exp_q     <= r_exp_d;
         acc_q       <= acc_d;
         ovf_q       <= ovf_d;
         unf_q       <= unf_d;
         out_valid_q <= out_valid_d;
      end
   end

   assign in_ready  = (state_q == S_IDLE);
   assign out_valid = out_valid_q;
   assign acc_out   = acc_q;
   assign ovf       = ovf_q;
   assign unf       = unf_q;

endmodule

// File: tb/tb_fp_mac_param.sv
// Self-checking bench for fp_mac_param (default FP8 E4M3): directed table,
// hand-written reset/handshake sequences, and random ops against a value-level model.
module tb_fp_mac_param;

   localparam int MAN_W = 3;
   localparam int GRD_W = 3;
   localparam int SIG_W = 7;
   localparam int BIAS  = 7;
   localparam int EMAX  = 15;

   logic       clk = 1'b0;
   logic       rst;
   logic       in_valid;
   logic       in_ready;
   logic [7:0] a_in, b_in;
   logic       op_clear;
   logic       out_valid;
   logic [7:0] acc_out;
   logic       ovf, unf;

   fp_mac_param dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a_in      (a_in),
      .b_in      (b_in),
      .op_clear  (op_clear),
      .out_valid (out_valid),
      .acc_out   (acc_out),
      .ovf       (ovf),
      .unf       (unf)
   );

   always #5 clk = ~clk;

   int tests = 0;
   int fails = 0;

   logic [7:0] m_acc;
   logic       m_ovf, m_unf;
   logic [7:0] exp_prev;

   typedef struct {
      logic [7:0] a;
      logic [7:0] b;
      logic       clr;
      logic [7:0] acc;
      logic       ovf;
      logic       unf;
   } vec_t;

   vec_t vec [10];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Value-level reference: signed integer significands with the stage truncations.
   task automatic model_op(input logic [7:0] a, input logic [7:0] b, input logic clr);
      int ea, eb, eacc, pm, am, pe, ae, e, s, mag;
      logic pz, az, neg;
      ea   = int'(a[6:3]);
      eb   = int'(b[6:3]);
      eacc = int'(m_acc[6:3]);
      if (clr) begin
         m_ovf = 1'b0;
         m_unf = 1'b0;
      end
      pz = (ea == 0) || (eb == 0);
      az = clr || (eacc == 0);
      pm = 0; pe = 0; am = 0; ae = 0;
      if (!pz) begin
         pm = (8 + int'(a[2:0])) * (8 + int'(b[2:0]));
         pe = ea + eb - BIAS;
         if (pm >= 128) begin
            pm = pm / 2;
            pe = pe + 1;
         end
         pm = (pm << GRD_W) >> MAN_W;
      end
      if (!az) begin
         am = (8 + int'(m_acc[2:0])) << GRD_W;
         ae = eacc;
      end
      if (pz)            e = ae;
      else if (az)       e = pe;
      else if (pe >= ae) begin
         e  = pe;
         am = (pe - ae > SIG_W) ? 0 : (am >> (pe - ae));
      end else begin
         e  = ae;
         pm = (ae - pe > SIG_W) ? 0 : (pm >> (ae - pe));
      end
      s = ((a[7] ^ b[7]) ? -pm : pm) + (m_acc[7] ? -am : am);
      if (s == 0) begin
         m_acc = 8'h00;
      end else begin
         neg = (s < 0);
         mag = neg ? -s : s;
         while (mag >= (1 << SIG_W)) begin
            mag = mag / 2;
            e   = e + 1;
         end
         while (mag < (1 << (SIG_W - 1))) begin
            mag = mag * 2;
            e   = e - 1;
         end
         if (e > EMAX) begin
            m_acc = {neg, 7'h7F};
            m_ovf = 1'b1;
         end else if (e < 1) begin
            m_acc = 8'h00;
            m_unf = 1'b1;
         end else begin
            m_acc = {neg, 4'(e), 3'((mag >> GRD_W) & 7)};
         end
      end
   endtask

   // Issue one op and check the 5-cycle handshake timing and result.
   task automatic do_op(input logic [7:0] a, input logic [7:0] b, input logic clr, input logic hold,
                        input logic [7:0] e_acc, input logic e_ovf, input logic e_unf, input string tag);
      @(negedge clk);
      chk({tag, "_ready"}, 32'(in_ready), 32'd1);
      chk({tag, "_nopulse"}, 32'(out_valid), 32'd0);
      a_in     = a;
      b_in     = b;
      op_clear = clr;
      in_valid = 1'b1;
      @(negedge clk);
      for (int k = 1; k <= 4; k++) begin
         if (hold) begin
            a_in     = 8'($urandom);
            b_in     = 8'($urandom);
            op_clear = 1'b1;
         end else begin
            in_valid = 1'b0;
         end
         chk({tag, "_busy"}, {30'd0, in_ready, out_valid}, 32'd0);
         if (k == 4) chk({tag, "_acchold"}, 32'(acc_out), 32'(exp_prev));
         @(negedge clk);
      end
      in_valid = 1'b0;
      chk({tag, "_valid"}, 32'(out_valid), 32'd1);
      chk({tag, "_acc"}, 32'(acc_out), 32'(e_acc));
      chk({tag, "_flags"}, {30'd0, ovf, unf}, {30'd0, e_ovf, e_unf});
      exp_prev = e_acc;
   endtask

   initial begin
      int seen;
      logic [7:0] ra, rb;
      logic rc;

      vec[0] = '{8'h38, 8'h38, 1'b1, 8'h38, 1'b0, 1'b0};
      vec[1] = '{8'h3C, 8'h40, 1'b0, 8'h48, 1'b0, 1'b0};
      vec[2] = '{8'hC0, 8'h40, 1'b0, 8'h00, 1'b0, 1'b0};
      vec[3] = '{8'h7F, 8'h7F, 1'b1, 8'h7F, 1'b1, 1'b0};
      vec[4] = '{8'h38, 8'h38, 1'b0, 8'h7F, 1'b1, 1'b0};
      vec[5] = '{8'h38, 8'h38, 1'b1, 8'h38, 1'b0, 1'b0};
      vec[6] = '{8'h08, 8'h08, 1'b1, 8'h00, 1'b0, 1'b1};
      vec[7] = '{8'h00, 8'h7F, 1'b0, 8'h00, 1'b0, 1'b1};
      vec[8] = '{8'h38, 8'hB8, 1'b1, 8'hB8, 1'b0, 1'b0};
      vec[9] = '{8'h30, 8'h38, 1'b0, 8'hB0, 1'b0, 1'b0};

      rst      = 1'b1;
      in_valid = 1'b0;
      a_in     = 8'h00;
      b_in     = 8'h00;
      op_clear = 1'b0;
      m_acc    = 8'h00;
      m_ovf    = 1'b0;
      m_unf    = 1'b0;
      exp_prev = 8'h00;
      repeat (3) @(negedge clk);
      chk("reset_outs", {22'd0, out_valid, acc_out, ovf, unf}, 32'd0);
      rst = 1'b0;
      @(negedge clk);
      chk("reset_ready", 32'(in_ready), 32'd1);

      for (int i = 0; i < 10; i++) begin
         model_op(vec[i].a, vec[i].b, vec[i].clr);
         do_op(vec[i].a, vec[i].b, vec[i].clr, 1'b0, vec[i].acc, vec[i].ovf, vec[i].unf,
               $sformatf("vec%0d", i));
      end

      // Truncation toward zero: 1.875*1.875 = 3.515625 -> 3.5.
      model_op(8'h3F, 8'h3F, 1'b1);
      do_op(8'h3F, 8'h3F, 1'b1, 1'b0, 8'h46, 1'b0, 1'b0, "trunc");

      // in_valid held with other operands during busy cycles: only one op accepted.
      model_op(8'h38, 8'h38, 1'b1);
      do_op(8'h38, 8'h38, 1'b1, 1'b1, 8'h38, 1'b0, 1'b0, "hold");
      model_op(8'h38, 8'h38, 1'b0);
      do_op(8'h38, 8'h38, 1'b0, 1'b0, 8'h40, 1'b0, 1'b0, "after_hold");

      // Mid-op reset with nonzero accumulator and ovf set.
      model_op(8'h7F, 8'h7F, 1'b1);
      do_op(8'h7F, 8'h7F, 1'b1, 1'b0, 8'h7F, 1'b1, 1'b0, "pre_rst");
      @(negedge clk);
      a_in     = 8'h38;
      b_in     = 8'h38;
      op_clear = 1'b1;
      in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      #1;
      chk("midrst_outs", {22'd0, out_valid, acc_out, ovf, unf}, 32'd0);
      @(negedge clk);
      rst  = 1'b0;
      seen = 0;
      for (int k = 0; k < 8; k++) begin
         @(negedge clk);
         if (out_valid) seen++;
      end
      chk("midrst_no_valid", 32'(seen), 32'd0);
      chk("midrst_ready", 32'(in_ready), 32'd1);
      m_acc    = 8'h00;
      m_ovf    = 1'b0;
      m_unf    = 1'b0;
      exp_prev = 8'h00;

      for (int i = 0; i < 300; i++) begin
         ra = 8'($urandom);
         rb = 8'($urandom);
         if ($urandom_range(0, 1) == 0) ra[6:3] = 4'($urandom_range(4, 10));
         if ($urandom_range(0, 1) == 0) rb[6:3] = 4'($urandom_range(4, 10));
         rc = ($urandom_range(0, 3) == 0);
         model_op(ra, rb, rc);
         do_op(ra, rb, rc, 1'b0, m_acc, m_ovf, m_unf, $sformatf("rnd%0d", i));
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
